// File: rtl/bitrev_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry output register that holds the bit-reversed word.
// Define BITREV_ARBITER_STATS_EN to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).
module bitrev_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s0_valid,
  input  logic                  s1_valid,
  output logic                  s0_ready,
  output logic                  s1_ready,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_src
`ifdef BITREV_ARBITER_STATS_EN
  ,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_src;

  logic                  w_accept;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_grant;
  logic [DATA_WIDTH-1:0] w_word;

  function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = d[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

  // rst_n gates acceptance so no ready can rise while reset is held.
  assign w_accept = rst_n && ((r_state == ST_EMPTY) || m_ready);
  assign w_grant0 = w_accept && s0_valid && (!s1_valid || r_last_grant);
  assign w_grant1 = w_accept && s1_valid && (!s0_valid || !r_last_grant);
  assign w_grant  = w_grant0 || w_grant1;
  assign w_word   = w_grant1 ? s1_data : s0_data;

  assign s0_ready = w_grant0;
  assign s1_ready = w_grant1;

  assign m_valid  = (r_state == ST_FULL);
  assign m_data   = r_data;
  assign m_src    = r_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_data       <= '0;
      r_src        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_grant) begin
            r_state      <= ST_FULL;
            r_data       <= bit_reverse(w_word);
            r_src        <= w_grant1;
            r_last_grant <= w_grant1;
          end
        end
        ST_FULL: begin
          // A grant here implies m_ready, so the old result leaves as the new one loads.
          if (w_grant) begin
            r_state      <= ST_FULL;
            r_data       <= bit_reverse(w_word);
            r_src        <= w_grant1;
            r_last_grant <= w_grant1;
          end else if (m_ready) begin
            r_state      <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef BITREV_ARBITER_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (w_grant0) r_grant_cnt0 <= sat_inc(r_grant_cnt0);
      if (w_grant1) r_grant_cnt1 <= sat_inc(r_grant_cnt1);
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_bitrev_arbiter.sv
// Directed testbench for bitrev_arbiter: reset, single word, conflict, backpressure, streaming, mid-op reset.
module tb_bitrev_arbiter;

  logic       clk;
  logic       rst_n;
  logic       s0_valid, s1_valid;
  logic       s0_ready, s1_ready;
  logic [7:0] s0_data, s1_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_src;
`ifdef BITREV_ARBITER_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bitrev_arbiter #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0_valid (s0_valid),
    .s1_valid (s1_valid),
    .s0_ready (s0_ready),
    .s1_ready (s1_ready),
    .s0_data  (s0_data),
    .s1_data  (s1_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_src    (m_src)
`ifdef BITREV_ARBITER_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, v});
    chk({tag, ".m_data"},  {24'd0, m_data},  {24'd0, d});
    chk({tag, ".m_src"},   {31'd0, m_src},   {31'd0, s});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".s0_ready"}, {31'd0, s0_ready}, {31'd0, r0});
    chk({tag, ".s1_ready"}, {31'd0, s1_ready}, {31'd0, r1});
  endtask

  initial begin
    rst_n = 1'b0; s0_valid = 1'b1; s1_valid = 1'b1;
    s0_data = 8'h00; s1_data = 8'h00; m_ready = 1'b1;

    // Reset state, with requests pending to show ready is suppressed.
    step(); step();
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    chk_rdy("rst", 1'b0, 1'b0);
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk_out("idle", 1'b0, 8'h00, 1'b0);

    // Conflict after reset: s0 first, then s1.
    s0_valid = 1'b1; s0_data = 8'b00000001;
    s1_valid = 1'b1; s1_data = 8'b10010100;
    m_ready = 1'b1;
    #1 chk_rdy("conf0", 1'b1, 1'b0);
    step();
    s0_valid = 1'b0;
    chk_out("conf0", 1'b1, 8'b10000000, 1'b0);
    #1 chk_rdy("conf1", 1'b0, 1'b1);
    step();
    s1_valid = 1'b0;
    chk_out("conf1", 1'b1, 8'b00101001, 1'b1);
    step();
    chk("conf.drain", {31'd0, m_valid}, 32'd0);

    // Single word.
    s0_valid = 1'b1; s0_data = 8'b00100111;
    #1 chk_rdy("single", 1'b1, 1'b0);
    step();
    s0_valid = 1'b0;
    chk_out("single", 1'b1, 8'b11100100, 1'b0);
    step();
    chk("single.drain", {31'd0, m_valid}, 32'd0);

    // Backpressure: s1 word held for 5 cycles while both requesters wait.
    m_ready = 1'b0;
    s1_valid = 1'b1; s1_data = 8'b00000101;
    #1 chk_rdy("bp.load", 1'b0, 1'b1);
    step();
    s0_valid = 1'b1; s0_data = 8'h33;
    s1_data = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_out("bp.hold", 1'b1, 8'b10100000, 1'b1);
      chk_rdy("bp.hold", 1'b0, 1'b0);
      step();
    end
    m_ready = 1'b1;
    #1 chk_rdy("bp.release", 1'b1, 1'b0);
    step();
    s0_valid = 1'b0;
    chk_out("bp.s0", 1'b1, 8'hCC, 1'b0);
    #1 chk_rdy("bp.s1", 1'b0, 1'b1);
    step();
    s1_valid = 1'b0;
    chk_out("bp.s1", 1'b1, 8'hF0, 1'b1);
    step();
    chk("bp.drain", {31'd0, m_valid}, 32'd0);

    // Streaming: alternation 0,1,0,1... at one word per cycle.
    s0_valid = 1'b1; s0_data = 8'h01;
    s1_valid = 1'b1; s1_data = 8'h03;
    for (int i = 0; i < 8; i++) begin
      #1 chk_rdy("stream.rdy", (i % 2) == 0, (i % 2) == 1);
      step();
      chk_out("stream.out", 1'b1, ((i % 2) == 1) ? 8'hC0 : 8'h80, (i % 2) == 1);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    step();
    chk("stream.drain", {31'd0, m_valid}, 32'd0);

    // Reset while FULL, with last grant pointing at s0.
    m_ready = 1'b0;
    s0_valid = 1'b1; s0_data = 8'b00100111;
    step();
    s0_valid = 1'b0;
    chk_out("mid.full", 1'b1, 8'b11100100, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("mid.rst", 1'b0, 8'h00, 1'b0);
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    step();
    chk("mid.nodup", {31'd0, m_valid}, 32'd0);
    s0_valid = 1'b1; s0_data = 8'b00000001;
    s1_valid = 1'b1; s1_data = 8'b10010100;
    #1 chk_rdy("mid.conf", 1'b1, 1'b0);
    step();
    s0_valid = 1'b0;
    chk_out("mid.conf0", 1'b1, 8'b10000000, 1'b0);
    step();
    s1_valid = 1'b0;
    chk_out("mid.conf1", 1'b1, 8'b00101001, 1'b1);
    step();

    // Fresh reset, then 5 grants to s1 and 3 to s0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    s1_valid = 1'b1; s1_data = 8'h80;
    for (int i = 0; i < 5; i++) step();
    s1_valid = 1'b0;
    chk_out("cnt.s1", 1'b1, 8'h01, 1'b1);
    s0_valid = 1'b1; s0_data = 8'h40;
    for (int i = 0; i < 3; i++) step();
    s0_valid = 1'b0;
    chk_out("cnt.s0", 1'b1, 8'h02, 1'b0);
`ifdef BITREV_ARBITER_STATS_EN
    chk("grant_cnt0", {16'd0, grant_cnt0}, 32'd3);
    chk("grant_cnt1", {16'd0, grant_cnt1}, 32'd5);
`endif
    step();
    chk("end.drain", {31'd0, m_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bitrev_arbiter.md
BITREV_ARBITER -- requirements
Module: bitrev_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, setting the data width of all data ports.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports s0_valid/s1_valid  input  1 each  requester 0/1 has a word.
REQ-005 SHALL have ports s0_ready/s1_ready  output  1 each  requester 0/1 word accepted this cycle.
REQ-006 SHALL have ports s0_data/s1_data  input  DATA_WIDTH each  requester words to reverse.
REQ-007 SHALL have port m_valid  output  1  output register holds a result.
REQ-008 SHALL have port m_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  bit-reversed word, m_data[i] = source[DATA_WIDTH-1-i].
REQ-010 SHALL have port m_src  output  1  index of the requester that produced m_data.

Function
REQ-011 SHALL implement a two-state FSM: EMPTY (output register empty) and FULL (result held).
REQ-012 SHALL define accept = (state==EMPTY) or (state==FULL and m_ready).
REQ-013 SHALL grant at most one requester per cycle, and only when accept is true.
REQ-014 SHALL, with only one sN_valid high, grant that requester.
REQ-015 SHALL, with both valid, grant the requester not granted last (round robin); last_grant resets to 1, so requester 0 wins the first conflict.
REQ-016 SHALL update last_grant only on an actual grant; idle cycles do not rotate priority.
REQ-017 SHALL drive sN_ready high only in the cycle requester N is granted; sN_ready is combinational on sN_valid, state and m_ready.
REQ-018 SHALL load the reversed granted word into m_data and the grantee index into m_src on the granting edge; latency is 1 cycle, input handshake to m_valid.
REQ-019 SHALL transition EMPTY->FULL on grant; FULL->EMPTY on m_ready without grant; FULL->FULL on m_ready with grant (back-to-back, 1 word/cycle); FULL->FULL holding on !m_ready.
REQ-020 SHALL keep m_data, m_src and m_valid stable while m_valid and !m_ready.
REQ-021 SHALL never drop or duplicate a word: each sN handshake yields exactly one m handshake, in grant order.
REQ-022 SHALL require requesters to hold valid and data stable until ready; no requirement applies when a requester withdraws before ready.

Reset
REQ-023 SHALL, while rst_n is low, force state=EMPTY, m_valid=0, m_data=0, m_src=0, last_grant=1, s0_ready=s1_ready=0.
REQ-024 SHALL discard any held result when reset asserts mid-operation; no output handshake occurs for it.
REQ-025 SHALL resume arbitration on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro BITREV_ARBITER_STATS_EN defined, add output ports grant_cnt0 and grant_cnt1, 16 bits each.
REQ-027 SHALL, with the macro defined, increment grant_cntN on each requester-N grant, saturate at 16'hFFFF, and reset to 0.
REQ-028 SHALL, without the macro, omit the grant_cnt ports and counter logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover a single word: s0 sends 8'b00100111 with m_ready=1 -> next cycle m_valid=1, m_data=8'b11100100, m_src=0.
REQ-030 SHALL cover a conflict after reset: s0=8'b00000001 and s1=8'b10010100 both valid -> s0 is granted first (m_data=8'b10000000, m_src=0), then s1 (m_data=8'b00101001, m_src=1) on consecutive cycles.
REQ-031 SHALL cover backpressure: m_ready=0 for 5 cycles with FULL holding 8'b10100000 from s1 input 8'b00000101 -> m_data is stable, both sN_ready=0, then one handshake when m_ready rises.
REQ-032 SHALL cover streaming: both requesters valid for 8 cycles with m_ready=1 -> grants alternate 0,1,0,1..., with 8 outputs in 8 consecutive cycles.
REQ-033 SHALL cover reset mid-operation: rst_n low while FULL -> m_valid=0 and m_data=0 immediately, and after release s0 wins the next conflict.
REQ-034 SHALL cover, with BITREV_ARBITER_STATS_EN, 3 grants to s0 and 5 to s1 -> grant_cnt0=3 and grant_cnt1=5.
